// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Bridges the MEM stage's 32-bit word loads/stores onto an external 16-bit
// asynchronous SRAM as two sequenced half-word cycles (low half first).
// Each half-word phase is held for WAIT_CYCLES+1 clocks. ready stays low
// while an access is in flight, so the top level can freeze the pipeline.
// All SRAM-facing outputs are registered.
//
// Optional build macro: SRAM_ADDR_CHECK_EN
//   Adds the addr_error output. Out-of-range requests finish in DONE without
//   any SRAM cycles. Without the macro, addresses wrap modulo the SRAM size.
module sram_mem_controller #(
    parameter int ADDRESS_LEN   = 32,
    parameter int DATA_LEN      = 32,
    parameter int SRAM_ADDR_LEN = 18,
    parameter int SRAM_DATA_LEN = 16,
    parameter int BASE_ADDR     = 1024,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [ADDRESS_LEN-1:0]   address,
    input  logic [DATA_LEN-1:0]      write_data,
    output logic [DATA_LEN-1:0]      read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_dq_oe,
    output logic                     sram_we_n,
    output logic                     sram_oe_n
`ifdef SRAM_ADDR_CHECK_EN
    ,
    output logic                     addr_error
`endif
);

    // One SRAM address bit selects the half-word, the rest index the word.
    localparam int WORD_LEN = SRAM_ADDR_LEN - 1;
    localparam int HALF     = SRAM_DATA_LEN;

    localparam logic [ADDRESS_LEN-1:0] BASE     = ADDRESS_LEN'(BASE_ADDR);
    localparam logic [2:0]             LAST_CNT = 3'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t                   state_q;
    logic [2:0]               cnt_q;
    logic [WORD_LEN-1:0]      word_q;
    logic [DATA_LEN-1:0]      wdata_q;
    logic [HALF-1:0]          lo_q;
    logic [DATA_LEN-1:0]      read_data_q;
    logic [SRAM_ADDR_LEN-1:0] sram_addr_q;
    logic [SRAM_DATA_LEN-1:0] sram_dq_out_q;
    logic                     sram_dq_oe_q;
    logic                     sram_we_n_q;
    logic                     sram_oe_n_q;
`ifdef SRAM_ADDR_CHECK_EN
    logic                     addr_error_q;
`endif

    logic [ADDRESS_LEN-1:0]   offset_d;
    logic [WORD_LEN-1:0]      word_d;
    logic                     addr_bad_d;
    logic                     last_d;
    logic                     we_hold_d;
    logic                     unused_addr_bits;

    // Translate the CPU byte address into a (wrapping) SRAM word index.
    always_comb begin
        offset_d = address - BASE;
        word_d   = offset_d[WORD_LEN+1:2];
`ifdef SRAM_ADDR_CHECK_EN
        // Below the base, or beyond the last word the SRAM can hold.
        addr_bad_d = (address < BASE) || (|offset_d[ADDRESS_LEN-1:WORD_LEN+2]);
`else
        addr_bad_d = 1'b0;
`endif
    end

    // Byte-lane bits and the wrapped-away upper bits are deliberately dropped.
    assign unused_addr_bits = ^{offset_d[1:0], offset_d[ADDRESS_LEN-1:WORD_LEN+2]};

    // Phase timing: last cycle of a phase, and whether the next cycle is the
    // write hold cycle (we_n released while address and data stay put).
    always_comb begin
        last_d    = (cnt_q == LAST_CNT);
        we_hold_d = ((cnt_q + 3'd1) == LAST_CNT);
    end

    // Freeze request: only IDLE without a request and the DONE cycle are ready.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            IDLE:    ready = !(rd_en || wr_en);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Access sequencer with registered SRAM strobes, address and data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            word_q        <= '0;
            wdata_q       <= '0;
            lo_q          <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
            addr_error_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if ((wr_en || rd_en) && addr_bad_d) begin
                        // Rejected request: no SRAM cycles, a read returns zero.
                        state_q <= DONE;
                        if (!wr_en) begin
                            read_data_q <= '0;
                        end
`ifdef SRAM_ADDR_CHECK_EN
                        addr_error_q <= 1'b1;
`endif
                    end else if (wr_en) begin
                        // Stores win over loads when both are requested.
                        state_q       <= WR_LO;
                        word_q        <= word_d;
                        wdata_q       <= write_data;
                        sram_addr_q   <= {word_d, 1'b0};
                        sram_dq_out_q <= write_data[HALF-1:0];
                        sram_dq_oe_q  <= 1'b1;
                        sram_we_n_q   <= 1'b0;
                    end else if (rd_en) begin
                        state_q     <= RD_LO;
                        word_q      <= word_d;
                        sram_addr_q <= {word_d, 1'b0};
                        sram_oe_n_q <= 1'b0;
                    end
                end

                WR_LO: begin
                    if (last_d) begin
                        state_q       <= WR_HI;
                        cnt_q         <= '0;
                        sram_addr_q   <= {word_q, 1'b1};
                        sram_dq_out_q <= wdata_q[DATA_LEN-1:HALF];
                        sram_we_n_q   <= 1'b0;
                    end else begin
                        cnt_q       <= cnt_q + 3'd1;
                        sram_we_n_q <= we_hold_d;
                    end
                end

                WR_HI: begin
                    if (last_d) begin
                        state_q      <= DONE;
                        cnt_q        <= '0;
                        sram_dq_oe_q <= 1'b0;
                        sram_we_n_q  <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_q + 3'd1;
                        sram_we_n_q <= we_hold_d;
                    end
                end

                RD_LO: begin
                    if (last_d) begin
                        // Low half is staged so read_data only changes once the
                        // whole word is in.
                        state_q     <= RD_HI;
                        cnt_q       <= '0;
                        lo_q        <= sram_dq_in;
                        sram_addr_q <= {word_q, 1'b1};
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end

                RD_HI: begin
                    if (last_d) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        read_data_q <= {sram_dq_in, lo_q};
                        sram_oe_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end

                DONE: begin
                    // Pipeline advances on this edge; next request is new.
                    state_q <= IDLE;
                    cnt_q   <= '0;
`ifdef SRAM_ADDR_CHECK_EN
                    addr_error_q <= 1'b0;
`endif
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;
    assign sram_oe_n   = sram_oe_n_q;
`ifdef SRAM_ADDR_CHECK_EN
    assign addr_error  = addr_error_q;
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller (WAIT_CYCLES=1, BASE_ADDR=1024).
// The driver pushes the hand-computed expectation for every request; a
// negedge monitor follows each access on the SRAM bus and compares when
// ready rises.
`timescale 1ns/1ps
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
`ifdef SRAM_ADDR_CHECK_EN
    logic        addr_error;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_rd;
        bit          is_wr;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [17:0] lo;
        int          lat;
        int          n_we;
        int          n_oe;
        int          n_dqoe;
        int          n_lo;
        int          n_hi;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b1;

    logic [15:0] mem [0:(1<<18)-1];

    always #5 clk = ~clk;

    sram_mem_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
`ifdef SRAM_ADDR_CHECK_EN
        ,
        .addr_error (addr_error)
`endif
    );

    // Asynchronous SRAM model: reads while oe_n low, writes while we_n low.
    assign sram_dq_in = (!sram_oe_n) ? mem[sram_addr] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] = sram_dq_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one access spans from the first not-ready cycle to ready.
    exp_t        cur;
    bit          active = 1'b0;
    bit          held_bad;
    int          cyc, we_cnt, oe_cnt, dqoe_cnt, lo_cyc, hi_cyc;
    logic [31:0] prev_rd = '0;

    always @(negedge clk) begin
        if (!rst) begin
            active  = 1'b0;
            prev_rd = '0;
        end else begin
            if (!active && mon_en && !ready) begin
                check("pending_expect", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                active   = 1'b1;
                cyc      = 0;
                we_cnt   = 0;
                oe_cnt   = 0;
                dqoe_cnt = 0;
                lo_cyc   = 0;
                hi_cyc   = 0;
                held_bad = 1'b0;
            end else if (active) begin
                cyc++;
            end
            if (active) begin
                if (!sram_we_n) we_cnt++;
                if (!sram_oe_n) oe_cnt++;
                if (sram_dq_oe) dqoe_cnt++;
                if (cur.is_wr) begin
                    if (sram_dq_oe && sram_addr == cur.lo && sram_dq_out == cur.wdata[15:0]) lo_cyc++;
                    if (sram_dq_oe && sram_addr == 18'(cur.lo + 18'd1) && sram_dq_out == cur.wdata[31:16]) hi_cyc++;
                end else begin
                    if (!sram_oe_n && sram_addr == cur.lo) lo_cyc++;
                    if (!sram_oe_n && sram_addr == 18'(cur.lo + 18'd1)) hi_cyc++;
                end
                if (!ready && read_data !== prev_rd) held_bad = 1'b1;
                if (ready) begin
                    check($sformatf("latency lo=%0d", cur.lo), 32'(cyc), 32'(cur.lat));
                    check($sformatf("we_n_low_cycles lo=%0d", cur.lo), 32'(we_cnt), 32'(cur.n_we));
                    check($sformatf("oe_n_low_cycles lo=%0d", cur.lo), 32'(oe_cnt), 32'(cur.n_oe));
                    check($sformatf("dq_oe_cycles lo=%0d", cur.lo), 32'(dqoe_cnt), 32'(cur.n_dqoe));
                    check($sformatf("lo_phase_cycles lo=%0d", cur.lo), 32'(lo_cyc), 32'(cur.n_lo));
                    check($sformatf("hi_phase_cycles lo=%0d", cur.lo), 32'(hi_cyc), 32'(cur.n_hi));
                    check($sformatf("read_data_held lo=%0d", cur.lo), 32'(held_bad), 32'd0);
                    if (cur.is_rd) begin
                        check($sformatf("read_data lo=%0d", cur.lo), read_data, cur.rdata);
                        prev_rd = cur.rdata;
                    end
`ifdef SRAM_ADDR_CHECK_EN
                    check($sformatf("addr_error lo=%0d", cur.lo), 32'(addr_error), 32'(cur.err));
`endif
                    $display("txn rd=%0b wr=%0b lo=%0d lat=%0d read_data=0x%08h", cur.is_rd, cur.is_wr, cur.lo, cyc, read_data);
                    active = 1'b0;
                end
            end
        end
    end

    // Issue one request, record its expectation, hold it until ready.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rexp, input logic [17:0] lo, input bit err);
        exp_t e;
        int   n;
        e.is_rd  = rd && !wr;
        e.is_wr  = wr && !err;
        e.err    = err;
        e.rdata  = rexp;
        e.wdata  = wd;
        e.lo     = lo;
        e.lat    = err ? 1 : 5;
        e.n_we   = (wr && !err) ? 2 : 0;
        e.n_oe   = (!wr && !err) ? 4 : 0;
        e.n_dqoe = (wr && !err) ? 4 : 0;
        e.n_lo   = err ? 0 : 2;
        e.n_hi   = err ? 0 : 2;
        exp_q.push_back(e);
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 40);
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 40 cycles, addr=0x%08h", a);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        int n;
        mem[4] = 16'hA5A5;
        mem[5] = 16'h5A5A;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_read_data", read_data, 32'd0);
        check("reset_we_n", 32'(sram_we_n), 32'd1);
        check("reset_oe_n", 32'(sram_oe_n), 32'd1);
        check("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("reset_sram_addr", 32'(sram_addr), 32'd0);
        check("reset_dq_out", 32'(sram_dq_out), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0,        18'd0, 1'b0);
        do_req(1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 18'd0, 1'b0);
        do_req(1'b0, 1'b1, 32'd1028, 32'h12345678, 32'h0,        18'd2, 1'b0);
        do_req(1'b1, 1'b0, 32'd1032, 32'h0,        32'h5A5AA5A5, 18'd4, 1'b0);
        do_req(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'h0,        18'd8, 1'b0);
        do_req(1'b1, 1'b0, 32'd1040, 32'h0,        32'hCAFEF00D, 18'd8, 1'b0);
`ifdef SRAM_ADDR_CHECK_EN
        do_req(1'b1, 1'b0, 32'd1020, 32'h0,        32'h0,        18'd0, 1'b1);
`else
        // 1024 + 4*2^17 wraps back onto SRAM word 0.
        do_req(1'b1, 1'b0, 32'd525312, 32'h0,      32'hDEADBEEF, 18'd0, 1'b0);
`endif

        // Abort a store in its first phase with reset.
        mon_en     = 1'b0;
        wr_en      = 1'b1;
        address    = 32'd1424;
        write_data = 32'h0BADF00D;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sram_we_n && n < 20);
        check("abort_we_n_active", 32'(sram_we_n), 32'd0);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_oe_n", 32'(sram_oe_n), 32'd1);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_read_data", read_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        do_req(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
